// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC sequencer: FSM states, mode encodings
// and the default iteration geometry.
package cordic_pkg;

   localparam int N_ITER_DEF          = 16;
   localparam int WIDTH_SHIFT_BIT_DEF = 4;

   // Operation modes as sampled on the request interface
   localparam logic MODE_VEC = 1'b0;
   localparam logic MODE_ROT = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_ITER = 2'd2,
      ST_DONE = 2'd3
   } seq_state_t;

endpackage

// File: rtl/cordic_sequencer_if.sv
// Request/result interface between a controller (master) and the CORDIC
// sequencer (slave): operation request, replay vector and status/result.
interface cordic_sequencer_if
   import cordic_pkg::*;
#(
   parameter int N_ITER = N_ITER_DEF
) ();

   logic            start;
   logic            mode;
   logic            x_msb;
   logic [N_ITER:0] sigma_in;
   logic            busy;
   logic            done;
   logic [N_ITER:0] sigma_out;
   logic            sigma_valid;

   modport master (
      output start, mode, x_msb, sigma_in,
      input  busy, done, sigma_out, sigma_valid
   );

   modport slave (
      input  start, mode, x_msb, sigma_in,
      output busy, done, sigma_out, sigma_valid
   );

endinterface

// File: rtl/cordic_iter_cnt.sv
// Micro-rotation index counter: clear has priority over load, load over
// count enable. 'last' flags the index after which the sweep ends.
module cordic_iter_cnt
   import cordic_pkg::*;
#(
   parameter int N_ITER          = N_ITER_DEF,
   parameter int WIDTH_SHIFT_BIT = WIDTH_SHIFT_BIT_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       load,
   input  logic [WIDTH_SHIFT_BIT-1:0] load_val,
   input  logic                       en,
   output logic [WIDTH_SHIFT_BIT-1:0] cnt,
   output logic                       last
);

   localparam logic [WIDTH_SHIFT_BIT-1:0] LAST_VAL = WIDTH_SHIFT_BIT'(N_ITER - 2);
   localparam logic [WIDTH_SHIFT_BIT-1:0] ONE      = WIDTH_SHIFT_BIT'(1);

   // Index register; doubles as the shift amount seen by the process stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en) begin
         cnt <= cnt + ONE;
      end
   end

   assign last = (cnt == LAST_VAL);

endmodule

// File: rtl/cordic_sequencer.sv
// Control sequencer for one CORDIC process stage. Vectoring mode steers each
// micro-rotation from the stage's y sign and records the directions; rotation
// mode replays a direction vector captured from a vectoring partner.
module cordic_sequencer
   import cordic_pkg::*;
#(
   parameter int N_ITER          = N_ITER_DEF,
   parameter int WIDTH_SHIFT_BIT = WIDTH_SHIFT_BIT_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   cordic_sequencer_if.slave          req,
   input  logic                       sign_out,
   output logic                       sign_rotation,
   output logic [WIDTH_SHIFT_BIT-1:0] shift_bit,
   output logic                       sign_in,
   output logic                       sel,
   output logic                       ce
);

   // Index width large enough to address every bit of the sigma vector
   localparam int IDX_W = $clog2(N_ITER + 1);

   seq_state_t                 state;
   logic                       mode_r;
   logic                       sign_rot_r;
   logic [N_ITER:0]            sigma_lat;
   logic [N_ITER:0]            sigma_out_r;
   logic                       sigma_valid_r;
   logic                       ce_r;
   logic                       sel_r;
   logic                       busy_r;
   logic                       done_r;

   logic [WIDTH_SHIFT_BIT-1:0] it;
   logic                       it_last;
   logic [IDX_W-1:0]           idx;
   logic                       in_sweep;
   logic                       dir_bit;

   cordic_iter_cnt #(
      .N_ITER          (N_ITER),
      .WIDTH_SHIFT_BIT (WIDTH_SHIFT_BIT)
   ) u_iter_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (state == ST_DONE),
      .load     (state == ST_LOAD),
      .load_val ('0),
      .en       (state == ST_ITER),
      .cnt      (it),
      .last     (it_last)
   );

   assign idx      = IDX_W'(it);
   assign in_sweep = (state == ST_ITER) || (state == ST_DONE);

   // Direction of the current micro-rotation: live y sign while vectoring,
   // replayed bit while rotating. Vectoring keeps this one gate from sign_out.
   assign dir_bit  = (mode_r == MODE_ROT) ? sigma_lat[idx] : sign_out;

   // Replay vector is pure data; it is only consulted after a rotation start
   always_ff @(posedge clk) begin
      if (state == ST_IDLE && req.start && req.mode == MODE_ROT) begin
         sigma_lat <= req.sigma_in;
      end
   end

   // Sequencer FSM with registered control outputs and sigma recording
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         mode_r        <= MODE_VEC;
         sign_rot_r    <= 1'b0;
         sigma_out_r   <= '0;
         sigma_valid_r <= 1'b0;
         ce_r          <= 1'b0;
         sel_r         <= 1'b0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req.start) begin
                  state         <= ST_LOAD;
                  mode_r        <= req.mode;
                  sign_rot_r    <= (req.mode == MODE_ROT) ? req.sigma_in[N_ITER] : req.x_msb;
                  sigma_valid_r <= 1'b0;
                  ce_r          <= 1'b1;
                  sel_r         <= 1'b0;
                  busy_r        <= 1'b1;
               end
            end
            ST_LOAD: begin
               // The 90 degree pre-rotation is applied while loading
               sigma_out_r[N_ITER] <= sign_rot_r;
               state               <= ST_ITER;
               sel_r               <= 1'b1;
            end
            ST_ITER: begin
               sigma_out_r[idx] <= dir_bit;
               if (it_last) begin
                  state  <= ST_DONE;
                  ce_r   <= 1'b0;
                  done_r <= 1'b1;
               end
            end
            ST_DONE: begin
               // Final micro-rotation result lands in the stage this cycle
               sigma_out_r[idx] <= dir_bit;
               state            <= ST_IDLE;
               sel_r            <= 1'b0;
               busy_r           <= 1'b0;
               sigma_valid_r    <= 1'b1;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign sign_in         = in_sweep & dir_bit;
   assign sign_rotation   = sign_rot_r;
   assign shift_bit       = it;
   assign sel             = sel_r;
   assign ce              = ce_r;
   assign req.busy        = busy_r;
   assign req.done        = done_r;
   assign req.sigma_out   = sigma_out_r;
   assign req.sigma_valid = sigma_valid_r;

endmodule

// File: tb/tb_cordic_sequencer.sv
// Self-checking bench for cordic_sequencer: table of directed and random
// operations compared cycle by cycle against a timing-level reference model,
// plus hand-written reset, ignored-start and back-to-back sequences.
module tb_cordic_sequencer;
   import cordic_pkg::*;

   localparam int N = 16;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   cordic_sequencer_if #(.N_ITER(N)) bus ();

   logic          sign_out;
   logic          sign_rotation;
   logic [W-1:0]  shift_bit;
   logic          sign_in;
   logic          sel;
   logic          ce;

   // Process-stage stub: y sign follows a pattern indexed by shift_bit, or
   // random noise when the stage is being driven in rotation mode
   logic [N-1:0]  pat;
   logic          use_noise;
   logic          noise;
   assign sign_out = use_noise ? noise : pat[shift_bit];

   cordic_sequencer #(
      .N_ITER          (N),
      .WIDTH_SHIFT_BIT (W)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req           (bus),
      .sign_out      (sign_out),
      .sign_rotation (sign_rotation),
      .shift_bit     (shift_bit),
      .sign_in       (sign_in),
      .sel           (sel),
      .ce            (ce)
   );

   typedef struct {
      logic         mode;
      logic         x_msb;
      logic [N:0]   sigma_in;
      logic [N-1:0] pat;
      logic [N:0]   exp_sigma;
      int           pulse_at;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // Direction applied at micro-rotation i
   function automatic logic dir(input vec_t v, input int i);
      return v.mode ? v.sigma_in[i] : v.pat[i];
   endfunction

   function automatic logic [N:0] ref_sigma(input vec_t v);
      return v.mode ? v.sigma_in : {v.x_msb, v.pat};
   endfunction

   // Expected {busy,ce,sel,done,sign_in,sign_rotation,sigma_valid,shift_bit}
   // in cycle k+t, start accepted at edge k
   function automatic logic [10:0] ref_cycle(input vec_t v, input int t);
      logic b, c, s, d, si, sr, sv;
      logic [W-1:0] sh;
      b = 0; c = 0; s = 0; d = 0; si = 0; sv = 0; sh = '0;
      sr = v.mode ? v.sigma_in[N] : v.x_msb;
      if (t == 1) begin
         b = 1; c = 1;
      end else if (t <= N) begin
         b = 1; c = 1; s = 1; sh = W'(t - 2); si = dir(v, t - 2);
      end else if (t == N + 1) begin
         b = 1; s = 1; d = 1; sh = W'(N - 1); si = dir(v, N - 1);
      end else begin
         sv = 1;
      end
      return {b, c, s, d, si, sr, sv, sh};
   endfunction

   function automatic logic [10:0] act_bundle();
      return {bus.busy, ce, sel, bus.done, sign_in, sign_rotation, bus.sigma_valid, shift_bit};
   endfunction

   // Advance one clock; sample point is 2 time units after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
      noise = 1'($urandom_range(0, 1));
      #1;
   endtask

   task automatic run_op(input vec_t v, input string tag);
      bus.start    = 1'b1;
      bus.mode     = v.mode;
      bus.x_msb    = v.x_msb;
      bus.sigma_in = v.sigma_in;
      pat          = v.pat;
      use_noise    = v.mode;
      tick();
      bus.start = 1'b0;
      for (int t = 1; t <= N + 2; t++) begin
         check($sformatf("%s t=%0d", tag, t), 32'(act_bundle()), 32'(ref_cycle(v, t)));
         if (v.pulse_at != 0 && t == v.pulse_at) begin
            bus.start    = 1'b1;
            bus.mode     = ~v.mode;
            bus.x_msb    = ~v.x_msb;
            bus.sigma_in = ~v.sigma_in;
         end else begin
            bus.start = 1'b0;
         end
         if (t < N + 2) tick();
      end
      check({tag, " sigma_out"}, 32'(bus.sigma_out), 32'(v.exp_sigma));
   endtask

   vec_t tbl[$];
   vec_t v;
   int   load_at[$];

   initial begin
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.mode     = 1'b0;
      bus.x_msb    = 1'b0;
      bus.sigma_in = '0;
      pat          = '0;
      use_noise    = 1'b0;
      noise        = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset outputs", 32'(act_bundle()), 32'(0));
      check("reset sigma_out", 32'(bus.sigma_out), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table entries
      tbl.push_back('{mode: 1'b0, x_msb: 1'b1, sigma_in: 17'h0, pat: 16'hA5C3, exp_sigma: 17'h1A5C3, pulse_at: 0});
      tbl.push_back('{mode: 1'b1, x_msb: 1'b1, sigma_in: 17'h03C96, pat: 16'h0, exp_sigma: 17'h03C96, pulse_at: 0});
      tbl.push_back('{mode: 1'b0, x_msb: 1'b0, sigma_in: 17'h1FFFF, pat: 16'h0000, exp_sigma: 17'h00000, pulse_at: 0});
      tbl.push_back('{mode: 1'b1, x_msb: 1'b0, sigma_in: 17'h1FFFF, pat: 16'h0, exp_sigma: 17'h1FFFF, pulse_at: 0});
      tbl.push_back('{mode: 1'b0, x_msb: 1'b1, sigma_in: 17'h0, pat: 16'h8001, exp_sigma: 17'h18001, pulse_at: 4});
      tbl.push_back('{mode: 1'b1, x_msb: 1'b0, sigma_in: 17'h15A5A, pat: 16'h0, exp_sigma: 17'h15A5A, pulse_at: 4});
      // Randomized entries, expectations from the reference model
      for (int i = 0; i < 8; i++) begin
         v.mode      = 1'($urandom_range(0, 1));
         v.x_msb     = 1'($urandom_range(0, 1));
         v.sigma_in  = 17'($urandom);
         v.pat       = 16'($urandom);
         v.pulse_at  = (i % 3 == 0) ? int'($urandom_range(2, N)) : 0;
         v.exp_sigma = ref_sigma(v);
         tbl.push_back(v);
      end
      foreach (tbl[i]) run_op(tbl[i], $sformatf("op%0d", i));

      // Asynchronous reset mid-sweep, at shift_bit = 5
      v = '{mode: 1'b0, x_msb: 1'b1, sigma_in: 17'h0, pat: 16'h3C3C, exp_sigma: 17'h13C3C, pulse_at: 0};
      bus.start = 1'b1; bus.mode = v.mode; bus.x_msb = v.x_msb; pat = v.pat; use_noise = 1'b0;
      tick();
      bus.start = 1'b0;
      repeat (6) tick();
      check("pre-reset shift_bit", 32'(shift_bit), 32'(5));
      #1 rst_n = 1'b0;
      #1;
      check("async reset outputs", 32'(act_bundle()), 32'(0));
      check("async reset sigma_out", 32'(bus.sigma_out), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      run_op(v, "post-reset");

      // start held high for 60 cycles: one operation every N+2 cycles
      bus.start = 1'b1; bus.mode = 1'b0; bus.x_msb = 1'b0; pat = 16'($urandom); use_noise = 1'b0;
      for (int c = 1; c <= 75; c++) begin
         int ph;
         logic b, cc, s, d, sv;
         tick();
         if (c == 60) bus.start = 1'b0;
         ph = c % (N + 2);
         b  = (c < 72) && (ph != 0);
         cc = b && (ph <= N);
         s  = b && (ph >= 2);
         d  = b && (ph == N + 1);
         sv = !b;
         check($sformatf("hold c=%0d", c), 32'({bus.busy, ce, sel, bus.done, bus.sigma_valid}),
               32'({b, cc, s, d, sv}));
         if (ce && !sel) load_at.push_back(c);
      end
      check("hold load count", 32'(load_at.size()), 32'(4));
      for (int j = 0; j < 4; j++) begin
         check($sformatf("hold load %0d", j),
               32'((j < load_at.size()) ? load_at[j] : -1), 32'(1 + j * (N + 2)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
